// File: rtl/data_cache_dm_pkg.sv
// Shared types and default sizes for the direct-mapped data cache.
// The default backing-memory base comes from the _DATA_CACHE_OFFSET macro.
`ifndef _DATA_CACHE_OFFSET
`define _DATA_CACHE_OFFSET 32'h0000_0000
`endif

package data_cache_dm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StResp,
        StWrite
    } state_e;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

    localparam int unsigned DefaultNumLines  = 16;
    localparam int unsigned DefaultLineWords = 4;

    localparam logic [31:0] DefaultMemBase = `_DATA_CACHE_OFFSET;

endpackage

// File: rtl/data_cache_line_ram.sv
// Line data store: one asynchronous read port and one byte-enabled synchronous write port.
// Contents are not reset; the cache's valid bits decide whether a word is meaningful.
module data_cache_line_ram #(
    parameter  int unsigned Depth = 64,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic [AddrW-1:0] rd_addr,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be
);

    logic [31:0] mem [Depth];

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill and flush.
// Define DATA_CACHE_STATS_EN to add the o_hit_cnt / o_miss_cnt read statistics outputs.
module data_cache_dm
    import data_cache_dm_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DefaultNumLines,
    parameter int unsigned LINE_WORDS = DefaultLineWords,
    parameter logic [31:0] MEM_BASE   = DefaultMemBase
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_op_type,
    input  logic [31:0] i_address,
    input  logic [31:0] i_val,
    input  logic [3:0]  i_byte_en,
    input  logic        i_flush,
`ifdef DATA_CACHE_STATS_EN
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt,
`endif
    output logic        o_resp_valid,
    output logic [31:0] o_val,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned WordW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OffW  = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IdxW  = $clog2(NUM_LINES);
    localparam int unsigned TagW  = 32 - OffW - IdxW;
    localparam int unsigned RamAw = $clog2(NUM_LINES * LINE_WORDS);
    localparam logic [WordW-1:0] LastBeat = WordW'(LINE_WORDS - 1);

    state_e state_q, state_d;
    op_e    req_op;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [3:0]           req_be;
    logic [WordW-1:0]     beat_q;
    logic                 flush_pend_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TagW-1:0]      tag_q [NUM_LINES];

    logic [IdxW-1:0]  idx;
    logic [TagW-1:0]  tag;
    logic [WordW-1:0] word;
    logic             hit;
    logic [31:0]      line_base;
    logic             accept;
    logic             flush_now;
    logic             refill_beat;
    logic             refill_last;

    logic             ram_we;
    logic [RamAw-1:0] ram_ra;
    logic [RamAw-1:0] ram_wa;
    logic [31:0]      ram_rd;
    logic [31:0]      ram_wd;
    logic [3:0]       ram_wbe;

    assign idx       = IdxW'(req_addr >> OffW);
    assign tag       = TagW'(req_addr >> (OffW + IdxW));
    assign word      = WordW'((req_addr >> 2) & 32'(LINE_WORDS - 1));
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign line_base = (req_addr & ~32'((LINE_WORDS * 4) - 1)) - MEM_BASE;
    assign ram_ra    = RamAw'(32'(idx) * LINE_WORDS + 32'(word));

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        flush_now    = 1'b0;
        refill_beat  = 1'b0;
        refill_last  = 1'b0;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_val        = '0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_be     = '0;
        ram_we       = 1'b0;
        ram_wa       = ram_ra;
        ram_wd       = '0;
        ram_wbe      = '0;

        unique case (state_q)
            StIdle: begin
                // A flush (new or deferred) takes the cycle; requests wait behind it.
                if (i_flush || flush_pend_q) begin
                    flush_now = 1'b1;
                end else begin
                    o_req_ready = 1'b1;
                    if (i_req_valid) begin
                        accept  = 1'b1;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (req_op == OpWrite) begin
                    state_d = StWrite;
                end else if (hit) begin
                    o_resp_valid = 1'b1;
                    o_val        = ram_rd;
                    state_d      = StIdle;
                end else begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                o_mem_req  = 1'b1;
                o_mem_addr = (line_base + (32'(beat_q) << 2)) & ~32'h3;
                if (i_mem_ack) begin
                    refill_beat = 1'b1;
                    ram_we      = 1'b1;
                    ram_wa      = RamAw'(32'(idx) * LINE_WORDS + 32'(beat_q));
                    ram_wd      = i_mem_rdata;
                    ram_wbe     = 4'hF;
                    if (beat_q == LastBeat) begin
                        refill_last = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            StResp: begin
                o_resp_valid = 1'b1;
                o_val        = ram_rd;
                state_d      = StIdle;
            end
            StWrite: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = (req_addr - MEM_BASE) & ~32'h3;
                o_mem_wdata = req_wdata;
                o_mem_be    = req_be;
                if (i_mem_ack) begin
                    // Write-through: the line is only updated when already resident.
                    if (hit) begin
                        ram_we  = 1'b1;
                        ram_wd  = req_wdata;
                        ram_wbe = req_be;
                    end
                    o_resp_valid = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            req_op       <= OpRead;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_be       <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_op    <= op_e'(i_op_type);
                req_addr  <= i_address;
                req_wdata <= i_val;
                req_be    <= i_byte_en;
                beat_q    <= '0;
            end
            if (refill_beat) begin
                beat_q <= refill_last ? '0 : beat_q + 1'b1;
            end
            // Valid only on the final beat so an interrupted refill never looks resident.
            if (refill_last) begin
                valid_q[idx] <= 1'b1;
            end
            if (flush_now) begin
                valid_q      <= '0;
                flush_pend_q <= 1'b0;
            end else if (i_flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (refill_last) begin
            tag_q[idx] <= tag;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        lookup_read;

    assign lookup_read = (state_q == StLookup) && (req_op == OpRead);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup_read) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

    data_cache_line_ram #(
        .Depth (NUM_LINES * LINE_WORDS)
    ) u_line_ram (
        .clk     (i_clk),
        .rd_addr (ram_ra),
        .rd_data (ram_rd),
        .wr_en   (ram_we),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .wr_be   (ram_wbe)
    );

endmodule

// File: tb/tb_data_cache_dm.sv
// Self-checking bench for data_cache_dm: transaction-level cache model plus backing-memory responder.
// Honours DATA_CACHE_STATS_EN when the design is built with the statistics outputs.
module tb_data_cache_dm;

    localparam int unsigned NL = 16;
    localparam int unsigned LW = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_op_type = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_val = '0;
    logic [3:0]  i_byte_en = '0;
    logic        i_flush = 1'b0;
    logic        o_resp_valid;
    logic [31:0] o_val;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 i_clk = ~i_clk;

    data_cache_dm dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_op_type    (i_op_type),
        .i_address    (i_address),
        .i_val        (i_val),
        .i_byte_en    (i_byte_en),
        .i_flush      (i_flush),
`ifdef DATA_CACHE_STATS_EN
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt),
`endif
        .o_resp_valid (o_resp_valid),
        .o_val        (o_val),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beats_seen = 0;
    int resp_seen = 0;
    logic [31:0] last_val = '0;

    logic [31:0] mem [4096];
    logic [31:0] mm  [4096];

    bit          m_valid [NL];
    int unsigned m_tag   [NL];
    logic [31:0] m_line  [NL][LW];
    int          m_hits = 0;
    int          m_misses = 0;

    typedef struct {
        logic [31:0] val;
        bit          hit;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    resp_t exp_resp [$];
    beat_t exp_beat [$];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: acks one cycle after it sees a request, holds ack for one cycle.
    int ack_cnt = 0;
    always @(posedge i_clk) begin
        #2;
        if (i_mem_ack) begin
            i_mem_ack = 1'b0;
            ack_cnt   = 0;
        end else if (o_mem_req && i_rst_n) begin
            if (ack_cnt == 1) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem[o_mem_addr[13:2]];
                if (o_mem_we) mem[o_mem_addr[13:2]] = merge(mem[o_mem_addr[13:2]], o_mem_wdata, o_mem_be);
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Cache model: decide hit/miss and all expected traffic at accept time.
    task automatic model_accept();
        logic [31:0] a = i_address;
        int unsigned idx = (a / 16) % NL;
        int unsigned w   = (a / 4) % LW;
        int unsigned tg  = a / 256;
        int unsigned wi  = (a / 4) % 4096;
        bit h = m_valid[idx] && (m_tag[idx] == tg);
        if (!i_op_type) begin
            if (h) m_hits++; else m_misses++;
            if (!h) begin
                for (int k = 0; k < LW; k++) begin
                    exp_beat.push_back('{addr: (a & ~32'hF) + 32'(4 * k), we: 1'b0, wdata: '0, be: '0});
                    m_line[idx][k] = mm[((a & ~32'hF) / 4 + k) % 4096];
                end
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
            exp_resp.push_back('{val: m_line[idx][w], hit: h, cyc: cyc});
        end else begin
            exp_beat.push_back('{addr: a & ~32'h3, we: 1'b1, wdata: i_val, be: i_byte_en});
            mm[wi] = merge(mm[wi], i_val, i_byte_en);
            if (h) m_line[idx][w] = merge(m_line[idx][w], i_val, i_byte_en);
            exp_resp.push_back('{val: 32'h0, hit: 1'b0, cyc: cyc});
        end
    endtask

    always @(negedge i_clk) begin
        resp_t r;
        beat_t b;
        cyc++;
        if (!i_rst_n) begin
            exp_resp.delete();
            exp_beat.delete();
            for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            m_hits   = 0;
            m_misses = 0;
            checks++;
            if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_val !== 32'h0 ||
                o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 ||
                o_mem_wdata !== 32'h0 || o_mem_be !== 4'h0) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%b rv=%b val=%h req=%b we=%b addr=%h wd=%h be=%h expected 1/0/0/0/0/0/0/0",
                         o_req_ready, o_resp_valid, o_val, o_mem_req, o_mem_we, o_mem_addr,
                         o_mem_wdata, o_mem_be);
            end
        end else begin
            if (o_resp_valid) begin
                checks++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got val=%h expected no response", o_val);
                end else begin
                    r = exp_resp.pop_front();
                    if (o_val !== r.val) begin
                        errors++;
                        $display("FAIL resp_val: got %h expected %h", o_val, r.val);
                    end
                    if (r.hit) begin
                        checks++;
                        if (cyc != r.cyc + 1) begin
                            errors++;
                            $display("FAIL hit_latency: got %0d cycles expected 1", cyc - r.cyc);
                        end
                    end
                end
                last_val = o_val;
                resp_seen++;
            end
            if (o_mem_req) begin
                checks++;
                if (exp_beat.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_req: got addr=%h we=%b expected no request",
                             o_mem_addr, o_mem_we);
                end else if (i_mem_ack) begin
                    b = exp_beat.pop_front();
                    if (o_mem_addr !== b.addr || o_mem_we !== b.we ||
                        (b.we && (o_mem_wdata !== b.wdata || o_mem_be !== b.be))) begin
                        errors++;
                        $display("FAIL mem_beat: got addr=%h we=%b wd=%h be=%h expected addr=%h we=%b wd=%h be=%h",
                                 o_mem_addr, o_mem_we, o_mem_wdata, o_mem_be,
                                 b.addr, b.we, b.wdata, b.be);
                    end
                    beats_seen++;
                end
            end
            if (i_flush) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            if (i_req_valid && o_req_ready) model_accept();
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] val,
                          input logic [3:0] be, output logic [31:0] rv, output int nbeats);
        int n0 = beats_seen;
        int r0 = resp_seen;
        int t = 0;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1;
        i_op_type   = we;
        i_address   = addr;
        i_val       = val;
        i_byte_en   = be;
        while (!o_req_ready && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no ready at %h expected accept", addr);
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        t = 0;
        while (resp_seen == r0 && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no response at %h expected one", addr);
        end
        rv     = last_val;
        nbeats = beats_seen - n0;
    endtask

    initial begin
        logic [31:0] rv;
        int nb, n0, t;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'hC0DE_0000 | 32'(i);
            mm[i]  = 32'hC0DE_0000 | 32'(i);
        end
        mem[32'h40] = 32'hDEAD_BEEF;
        mm[32'h40]  = 32'hDEAD_BEEF;

        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        do_req(1'b0, 32'h100, '0, '0, rv, nb);
        chk("read_100_val", rv, 32'hDEAD_BEEF);
        chk("read_100_beats", 32'(nb), 32'd4);
        do_req(1'b0, 32'h104, '0, '0, rv, nb);
        chk("reread_104_val", rv, 32'hC0DE_0041);
        chk("reread_104_beats", 32'(nb), 32'd0);

        do_req(1'b1, 32'h104, 32'h1122_3344, 4'b0011, rv, nb);
        chk("write_104_val", rv, 32'h0);
        chk("write_104_beats", 32'(nb), 32'd1);
        do_req(1'b0, 32'h104, '0, '0, rv, nb);
        chk("merged_104_val", rv, 32'hC0DE_3344);
        chk("merged_104_beats", 32'(nb), 32'd0);

        do_req(1'b1, 32'h108, 32'hFFFF_FFFF, 4'b0000, rv, nb);
        chk("write_be0_beats", 32'(nb), 32'd1);
        do_req(1'b0, 32'h108, '0, '0, rv, nb);
        chk("read_108_unchanged", rv, 32'hC0DE_0042);

        do_req(1'b1, 32'h800, 32'hCAFE_F00D, 4'b1111, rv, nb);
        chk("write_miss_beats", 32'(nb), 32'd1);
        do_req(1'b0, 32'h800, '0, '0, rv, nb);
        chk("read_800_val", rv, 32'hCAFE_F00D);
        chk("read_800_beats", 32'(nb), 32'd4);

        // Flush and request in the same idle cycle: flush wins.
        @(posedge i_clk); #1;
        i_flush = 1'b1; i_req_valid = 1'b1; i_op_type = 1'b0; i_address = 32'h104;
        #4 chk("flush_blocks_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_req_valid = 1'b0;
        do_req(1'b0, 32'h104, '0, '0, rv, nb);
        chk("after_flush_104_val", rv, 32'hC0DE_3344);
        chk("after_flush_104_beats", 32'(nb), 32'd4);

        // Flush raised during a refill is deferred until the refill responds.
        fork
            do_req(1'b0, 32'h210, '0, '0, rv, nb);
            begin
                repeat (3) @(posedge i_clk);
                #1 i_flush = 1'b1;
                @(posedge i_clk);
                #1 i_flush = 1'b0;
            end
        join
        chk("refill_during_flush_val", rv, 32'hC0DE_0084);
        chk("refill_during_flush_beats", 32'(nb), 32'd4);
        do_req(1'b0, 32'h100, '0, '0, rv, nb);
        chk("post_flush_100_val", rv, 32'hDEAD_BEEF);
        chk("post_flush_100_beats", 32'(nb), 32'd4);
        do_req(1'b0, 32'h210, '0, '0, rv, nb);
        chk("post_flush_210_beats", 32'(nb), 32'd4);
        do_req(1'b0, 32'h104, '0, '0, rv, nb);
        chk("post_flush_hit_beats", 32'(nb), 32'd0);

        // Reset in the middle of a refill.
        n0 = beats_seen;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_op_type = 1'b0; i_address = 32'h300;
        t = 0;
        while (!o_req_ready && t < 50) begin
            @(posedge i_clk); #1;
            t++;
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        t = 0;
        while (beats_seen - n0 < 2 && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        chk("abort_beats", 32'(beats_seen - n0), 32'd2);
        i_rst_n = 1'b0;
        #3;
        chk("midreset_ready", 32'(o_req_ready), 32'd1);
        chk("midreset_mem_req", 32'(o_mem_req), 32'd0);
        chk("midreset_mem_addr", o_mem_addr, 32'h0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        do_req(1'b0, 32'h100, '0, '0, rv, nb);
        chk("after_reset_100_val", rv, 32'hDEAD_BEEF);
        chk("after_reset_100_beats", 32'(nb), 32'd4);
        do_req(1'b0, 32'h300, '0, '0, rv, nb);
        chk("after_reset_300_val", rv, 32'hC0DE_00C0);
        chk("after_reset_300_beats", 32'(nb), 32'd4);

        repeat (3) @(posedge i_clk);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("beat_queue_empty", 32'(exp_beat.size()), 32'd0);
`ifdef DATA_CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion within 200000 time units");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
